// File: rtl/display_serial_driver_if.sv
// Frame request and serial-chain signals of the display serial driver.
// The client drives the frame request side; the driver owns the chain outputs.
interface display_serial_driver_if #(
  parameter int N = 48
);
  logic         start;
  logic [N-1:0] data;
  logic         blank;
  logic         invert;
  logic         busy;
  logic         done;
  logic         serial_out;
  logic         clk_out;
  logic         latch_out;

  modport master (
    output start, data, blank, invert,
    input  busy, done, serial_out, clk_out, latch_out
  );

  modport slave (
    input  start, data, blank, invert,
    output busy, done, serial_out, clk_out, latch_out
  );
endinterface

// File: rtl/display_serial_driver.sv
// Shifts a packed segment frame MSB-first into a 74HC595-style daisy chain,
// then pulses the storage latch. One start request can queue behind a frame.
module display_serial_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int BITS_PER_DIGIT = 8,
  parameter int CLK_DIV        = 2
) (
  input logic                    clk,
  input logic                    reset,
  display_serial_driver_if.slave bus
);
  localparam int N  = NUM_DIGITS * BITS_PER_DIGIT;
  localparam int BW = $clog2(N + 1);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(N - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic [N-1:0]  shift_reg, shift_next;
  logic          pending_reg, pending_next;
  logic          done_reg, done_next;
  logic [N-1:0]  load_word;
  logic          phase_last;

  // Blank forces a digit dark before the common-anode inversion is applied.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign load_word[gi*BITS_PER_DIGIT +: BITS_PER_DIGIT] =
        (bus.blank ? {BITS_PER_DIGIT{1'b0}} : bus.data[gi*BITS_PER_DIGIT +: BITS_PER_DIGIT])
        ^ {BITS_PER_DIGIT{bus.invert}};
    end
  endgenerate

  assign phase_last = (phase_reg == LAST_PHASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      pending_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      pending_reg <= pending_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    pending_next = pending_reg;
    done_next    = 1'b0;

    // Only one request queues; a start seen in IDLE is served directly.
    if (bus.start && (state_reg != IDLE)) begin
      pending_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (bus.start || pending_reg) begin
          state_next   = SHIFT_LO;
          phase_next   = '0;
          bit_next     = '0;
          shift_next   = load_word;
          pending_next = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (phase_last) begin
          state_next = SHIFT_HI;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_last) begin
          phase_next = '0;
          if (bit_reg == LAST_BIT) begin
            state_next = LATCH;
          end else begin
            // Advancing the data here keeps serial_out stable over the whole bit.
            state_next = SHIFT_LO;
            bit_next   = bit_reg + BW'(1);
            shift_next = shift_reg << 1;
          end
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      LATCH: begin
        if (phase_last) begin
          state_next = IDLE;
          phase_next = '0;
          done_next  = 1'b1;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = done_reg;
  assign bus.clk_out    = (state_reg == SHIFT_HI);
  assign bus.latch_out  = (state_reg == LATCH);
  assign bus.serial_out = ((state_reg == SHIFT_LO) || (state_reg == SHIFT_HI)) && shift_reg[N-1];

endmodule

// File: tb/tb_display_serial_driver.sv
// Drives three driver configurations and compares every cycle against a
// timeline model of each frame (bit index and phase derived from elapsed cycles).
module tb_display_serial_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-DUT configuration: 0 = 16 bits/div 1, 1 = 16 bits/div 3, 2 = defaults.
  int nn [3] = '{16, 16, 48};
  int cd [3] = '{1, 3, 2};

  logic        rs [3];
  logic        st [3];
  logic        bl [3];
  logic        iv [3];
  logic [47:0] dt [3];

  display_serial_driver_if #(.N(16)) if_a ();
  display_serial_driver_if #(.N(16)) if_b ();
  display_serial_driver_if #(.N(48)) if_c ();

  display_serial_driver #(.NUM_DIGITS(2), .BITS_PER_DIGIT(8), .CLK_DIV(1)) u_a (
    .clk(clk), .reset(rs[0]), .bus(if_a));
  display_serial_driver #(.NUM_DIGITS(2), .BITS_PER_DIGIT(8), .CLK_DIV(3)) u_b (
    .clk(clk), .reset(rs[1]), .bus(if_b));
  display_serial_driver u_c (
    .clk(clk), .reset(rs[2]), .bus(if_c));

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Reference model state: active frame, cycles since load, queued request.
  int          mk    [3];
  bit          mact  [3];
  bit          mpend [3];
  bit          mdone [3];
  logic [47:0] mword [3];

  // Observation bookkeeping.
  logic [4:0]  obs        [3];
  logic        prev_clk   [3];
  logic        prev_latch [3];
  logic [63:0] cap        [3];
  int          capn       [3];
  int          busy_cnt   [3];
  int          done_cnt   [3];
  int          latch_cnt  [3];
  int          rises_since[3];
  int          done_q[$];
  int          rises_q[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr(int d);
    cap[d] = '0; capn[d] = 0; busy_cnt[d] = 0; done_cnt[d] = 0;
    latch_cnt[d] = 0; rises_since[d] = 0;
  endtask

  task automatic model_step(int d);
    if (rs[d]) begin
      mact[d] = 0; mpend[d] = 0; mdone[d] = 0;
    end else if (mact[d]) begin
      if (st[d]) mpend[d] = 1;
      mk[d]++;
      mdone[d] = 0;
      if (mk[d] == 2*cd[d]*nn[d] + cd[d]) begin
        mact[d] = 0;
        mdone[d] = 1;
      end
    end else begin
      mdone[d] = 0;
      if (st[d] || mpend[d]) begin
        mact[d] = 1; mk[d] = 0; mpend[d] = 0;
        mword[d] = '0;
        for (int i = 0; i < nn[d]; i++)
          mword[d][i] = (bl[d] ? 1'b0 : dt[d][i]) ^ iv[d];
      end
    end
  endtask

  // Expected {busy, done, serial_out, clk_out, latch_out}.
  function automatic logic [4:0] expected(int d);
    logic [4:0] e;
    int b;
    e = '0;
    if (mact[d]) begin
      e[4] = 1'b1;
      b = mk[d] / (2*cd[d]);
      if (b < nn[d]) begin
        e[2] = mword[d][nn[d]-1-b];
        e[1] = ((mk[d] % (2*cd[d])) >= cd[d]);
      end else begin
        e[0] = 1'b1;
      end
    end else begin
      e[3] = mdone[d];
    end
    return e;
  endfunction

  task automatic tick();
    if_a.start = st[0]; if_a.blank = bl[0]; if_a.invert = iv[0]; if_a.data = dt[0][15:0];
    if_b.start = st[1]; if_b.blank = bl[1]; if_b.invert = iv[1]; if_b.data = dt[1][15:0];
    if_c.start = st[2]; if_c.blank = bl[2]; if_c.invert = iv[2]; if_c.data = dt[2];
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    obs[0] = {if_a.busy, if_a.done, if_a.serial_out, if_a.clk_out, if_a.latch_out};
    obs[1] = {if_b.busy, if_b.done, if_b.serial_out, if_b.clk_out, if_b.latch_out};
    obs[2] = {if_c.busy, if_c.done, if_c.serial_out, if_c.clk_out, if_c.latch_out};
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d_cycle%0d_outputs", d, cycle), 64'(obs[d]), 64'(expected(d)));
      if (obs[d][1] && !prev_clk[d]) begin
        cap[d] = {cap[d][62:0], obs[d][2]};
        capn[d]++;
        rises_since[d]++;
      end
      if (obs[d][0] && !prev_latch[d]) begin
        latch_cnt[d]++;
        if (d == 2) rises_q.push_back(rises_since[d]);
        rises_since[d] = 0;
      end
      if (obs[d][3]) begin
        done_cnt[d]++;
        if (d == 2) done_q.push_back(cycle);
      end
      if (obs[d][4]) busy_cnt[d]++;
      prev_clk[d]   = obs[d][1];
      prev_latch[d] = obs[d][0];
    end
    cycle++;
  endtask

  // Single frame on DUT A, then check the bits captured on clk_out rises.
  task automatic run_a(string tag, logic [15:0] data, logic blank, logic invert, logic [15:0] exp);
    clr(0);
    dt[0] = {32'h0, data}; bl[0] = blank; iv[0] = invert; st[0] = 1'b1;
    tick();
    st[0] = 1'b0; bl[0] = 1'b0; iv[0] = 1'b0;
    repeat (40) tick();
    chk({tag, "_bits"}, cap[0][15:0], {48'h0, exp});
    chk({tag, "_nbits"}, 64'(capn[0]), 64'd16);
  endtask

  initial begin
    logic [15:0] r16;
    logic        rb, ri;
    for (int d = 0; d < 3; d++) begin
      rs[d] = 1'b1; st[d] = 1'b0; bl[d] = 1'b0; iv[d] = 1'b0; dt[d] = '0;
      mk[d] = 0; mact[d] = 0; mpend[d] = 0; mdone[d] = 0; mword[d] = '0;
      prev_clk[d] = 1'b0; prev_latch[d] = 1'b0;
      clr(d);
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) chk($sformatf("reset_state_dut%0d", d), 64'(obs[d]), 64'd0);
    for (int d = 0; d < 3; d++) rs[d] = 1'b0;
    tick();

    // Basic frame: bit order, latch width, busy length, single done.
    run_a("frame_a53c", 16'hA53C, 1'b0, 1'b0, 16'hA53C);
    chk("frame_a53c_busy_cycles", 64'(busy_cnt[0]), 64'd33);
    chk("frame_a53c_latch_pulses", 64'(latch_cnt[0]), 64'd1);
    chk("frame_a53c_done_pulses", 64'(done_cnt[0]), 64'd1);

    // Invert and blank modes.
    run_a("invert_00ff", 16'h00FF, 1'b0, 1'b1, 16'hFF00);
    run_a("blank", 16'h5A5A, 1'b1, 1'b0, 16'h0000);
    run_a("blank_invert", 16'h5A5A, 1'b1, 1'b1, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      r16 = 16'($urandom); rb = 1'($urandom_range(0, 3) == 0); ri = 1'($urandom);
      run_a($sformatf("rand_frame%0d", i), r16, rb, ri, (rb ? 16'h0000 : r16) ^ {16{ri}});
    end

    // Divided serial clock.
    clr(1);
    r16 = 16'($urandom);
    dt[1] = {32'h0, r16}; st[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    repeat (110) tick();
    chk("div3_busy_cycles", 64'(busy_cnt[1]), 64'd99);
    chk("div3_bits", cap[1][15:0], {48'h0, r16});
    chk("div3_done_pulses", 64'(done_cnt[1]), 64'd1);

    // Queued request: latest data wins, only one extra frame.
    clr(0);
    dt[0] = 48'h1111; st[0] = 1'b1;
    tick();
    st[0] = 1'b0; repeat (5) tick();
    st[0] = 1'b1; tick();
    st[0] = 1'b0; repeat (5) tick();
    st[0] = 1'b1; tick();
    st[0] = 1'b0; dt[0] = 48'h2222;
    repeat (70) tick();
    chk("queue_bits", cap[0][31:0], 64'h11112222);
    chk("queue_nbits", 64'(capn[0]), 64'd32);
    chk("queue_done_pulses", 64'(done_cnt[0]), 64'd2);
    chk("queue_busy_cycles", 64'(busy_cnt[0]), 64'd66);

    // Reset mid-frame at bit 7, then a clean frame.
    clr(0);
    dt[0] = {32'h0, 16'($urandom)}; st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (14) tick();
    rs[0] = 1'b1; tick();
    rs[0] = 1'b0;
    chk("midreset_outputs", 64'(obs[0]), 64'd0);
    repeat (40) tick();
    chk("midreset_latch_pulses", 64'(latch_cnt[0]), 64'd0);
    chk("midreset_done_pulses", 64'(done_cnt[0]), 64'd0);
    rs[0] = 1'b1; st[0] = 1'b1; tick();
    rs[0] = 1'b0; st[0] = 1'b0;
    chk("reset_over_start_busy", 64'(obs[0][4]), 64'd0);
    r16 = 16'($urandom);
    run_a("after_reset", r16, 1'b0, 1'b0, r16);
    chk("after_reset_done_pulses", 64'(done_cnt[0]), 64'd1);

    // Start held high on default configuration: back-to-back frames.
    clr(2);
    done_q.delete(); rises_q.delete();
    st[2] = 1'b1;
    for (int i = 0; i < 700; i++) begin
      dt[2] = 48'({$urandom, $urandom});
      tick();
    end
    st[2] = 1'b0;
    repeat (200) tick();
    chk("holdstart_done_count_ge3", 64'(done_q.size() >= 3), 64'd1);
    // Period is the busy length (2*CLK_DIV*N + CLK_DIV) plus the done cycle.
    for (int i = 1; i < done_q.size(); i++)
      chk($sformatf("holdstart_done_period%0d", i), 64'(done_q[i] - done_q[i-1]), 64'(2*2*48 + 2 + 1));
    foreach (rises_q[i])
      chk($sformatf("holdstart_rises_per_latch%0d", i), 64'(rises_q[i]), 64'd48);

    // Random traffic on all configurations, checked cycle by cycle.
    for (int i = 0; i < 2500; i++) begin
      for (int d = 0; d < 3; d++) begin
        st[d] = ($urandom_range(0, 15) == 0);
        rs[d] = ($urandom_range(0, 399) == 0);
        bl[d] = ($urandom_range(0, 5) == 0);
        iv[d] = 1'($urandom);
        dt[d] = 48'({$urandom, $urandom});
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
